generate_lookup_inv: RTL



---
 rtl/generate_lookup_pkg.sv | 30 +++
 rtl/generate_lookup_pipe_stage.sv | 44 ++++
 rtl/generate_lookup_inv.sv | 119 +++++++++++
 3 files changed

// File: rtl/generate_lookup_pkg.sv
// ============================================================================
// Module      : generate_lookup_pkg
// Description : Shared types, map constants and forward/inverse lookup maps
//               for the generate-time lookup encoder and its inverse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package generate_lookup_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t LOOKUP_MUL     = 8'd3;
    localparam byte_t LOOKUP_MUL_INV = 8'd171;
    localparam byte_t LOOKUP_ADD     = 8'd5;

    // mode 1 selects the multiply map, anything else the add map
    function automatic byte_t lookup_encode(input byte_t x, input int mode);
        if (mode == 1) return x * LOOKUP_MUL;
        return x + LOOKUP_ADD;
    endfunction

    function automatic byte_t lookup_decode(input byte_t x, input int mode);
        if (mode == 1) return x * LOOKUP_MUL_INV;
        return x - LOOKUP_ADD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/generate_lookup_pipe_stage.sv
// ============================================================================
// Module      : generate_lookup_pipe_stage
// Description : Single valid/ready register slice; ready passes through
//               combinationally so a full slice can refill while draining.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module generate_lookup_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // data only moves on a load, so it holds while stalled and after draining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/generate_lookup_inv.sv
// ============================================================================
// Module      : generate_lookup_inv
// Description : Two-stage valid/ready inverse of the lookup encoder with a
//               transfer counter. Optional round-trip self check enabled by
//               macro GENERATE_LOOKUP_ROUNDTRIP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module generate_lookup_inv
    import generate_lookup_pkg::*;
#(
    parameter int ENABLE_PARAM = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_val,
    output logic [CNT_W-1:0] xfer_count,
    output logic             err
);

`ifdef GENERATE_LOOKUP_ROUNDTRIP_CHECK_EN
    localparam int S2_W = 16;
`else
    localparam int S2_W = 8;
`endif

    logic            w_s1_valid;
    logic            w_s2_ready;
    byte_t           w_s1_code;
    byte_t           w_dec;
    logic [S2_W-1:0] w_s2_in;
    logic [S2_W-1:0] w_s2_data;
    logic            w_out_xfer;

    logic [CNT_W-1:0] r_xfer_count;

    generate_lookup_pipe_stage #(
        .DATA_W (8)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_code),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_ready),
        .out_data  (w_s1_code)
    );

    // only the selected inverse map is elaborated
    generate
        if (ENABLE_PARAM == 1) begin : g_dec_mul
            assign w_dec = w_s1_code * LOOKUP_MUL_INV;
        end else begin : g_dec_add
            assign w_dec = w_s1_code - LOOKUP_ADD;
        end
    endgenerate

    generate_lookup_pipe_stage #(
        .DATA_W (S2_W)
    ) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_ready),
        .in_data   (w_s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_s2_data)
    );

    assign w_out_xfer = out_valid && out_ready;

`ifdef GENERATE_LOOKUP_ROUNDTRIP_CHECK_EN
    // S2 carries {original code, decoded byte}; the check re-encodes the port value
    byte_t w_stored_code;
    byte_t w_reenc;
    logic  r_err;

    assign w_s2_in       = {w_s1_code, w_dec};
    assign out_val       = w_s2_data[7:0];
    assign w_stored_code = w_s2_data[15:8];
    assign w_reenc       = lookup_encode(out_val, ENABLE_PARAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_out_xfer && (w_reenc != w_stored_code)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_s2_in = w_dec;
    assign out_val = w_s2_data;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (w_out_xfer) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign xfer_count = r_xfer_count;

endmodule

`default_nettype wire
